// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding, alu_op field layout and the
// decode helper used by the operand stage.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_RED    = 4'h2,
        OP_XOR    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LHB    = 4'hA,
        OP_LLB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_t;

    // alu_op = {out_sel[1:0], sat, red, sub, shiftop[1:0]}
    localparam int ALU_OP_W    = 7;
    localparam int OUT_SEL_LSB = 5;
    localparam int SAT_BIT     = 4;
    localparam int RED_BIT     = 3;
    localparam int SUB_BIT     = 2;
    localparam int SHIFT_LSB   = 0;

    localparam logic [1:0] OUT_SEL_ARITH = 2'b00;
    localparam logic [1:0] OUT_SEL_XOR   = 2'b01;
    localparam logic [1:0] OUT_SEL_SHIFT = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } halt_state_t;

    function automatic logic [ALU_OP_W-1:0] decode_alu_op(input opcode_t op,
                                                          input logic [1:0] shiftop);
        logic [ALU_OP_W-1:0] f;
        f = '0;
        f[OUT_SEL_LSB +: 2] = OUT_SEL_ARITH;
        f[SHIFT_LSB +: 2]   = shiftop;
        case (op)
            OP_XOR:                 f[OUT_SEL_LSB +: 2] = OUT_SEL_XOR;
            OP_SLL, OP_SRA, OP_ROR: f[OUT_SEL_LSB +: 2] = OUT_SEL_SHIFT;
            OP_PADDSB:              f[SAT_BIT] = 1'b1;
            OP_RED:                 f[RED_BIT] = 1'b1;
            OP_SUB:                 f[SUB_BIT] = 1'b1;
            default:                ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Forwarding mux for one operand: lowest set select bit wins, falls back to
// register-file data, and flags a select vector with more than one bit set.
module fwd_mux #(
    parameter int DW   = 16,
    parameter int NFWD = 2
) (
    input  logic [NFWD*DW-1:0] fwd_data,
    input  logic [NFWD-1:0]    fwd_sel,
    input  logic [DW-1:0]      reg_data,
    output logic [DW-1:0]      data_out,
    output logic               multi_sel
);

    // Scan from the top so the lowest index is applied last and wins.
    always_comb begin
        data_out = reg_data;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (fwd_sel[k]) begin
                data_out = fwd_data[k*DW +: DW];
            end
        end
    end

    assign multi_sel = (fwd_sel & (fwd_sel - NFWD'(1))) != '0;

endmodule

// File: rtl/ex_operand_stage.sv
// Execute-stage operand register: forwards, forms ALU operands per opcode and
// holds them behind a valid/ready handshake, with halt tracking and stall count.
module ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NFWD = 2,
    parameter int CW   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [15:0]         instr,
    input  logic [DW-1:0]       reg_data1,
    input  logic [DW-1:0]       reg_data2,
    input  logic [DW-1:0]       pcs,
    input  logic [NFWD*DW-1:0]  fwd_data,
    input  logic [NFWD-1:0]     fwd_sel_a,
    input  logic [NFWD-1:0]     fwd_sel_b,
    input  logic                flush,
    input  logic                ex_ready,
    output logic                ex_valid,
    output logic [DW-1:0]       alu_a,
    output logic [DW-1:0]       alu_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                halted,
    output logic [CW-1:0]       stall_cnt,
    output logic                fwd_err
);

    logic [DW-1:0]       raw_a;
    logic [DW-1:0]       raw_b;
    logic                multi_a;
    logic                multi_b;
    logic [DW-1:0]       next_a;
    logic [DW-1:0]       next_b;
    logic [ALU_OP_W-1:0] next_op;
    logic                load;
    opcode_t             opcode;
    halt_state_t         state_q;
    halt_state_t         state_d;
    logic                unused_instr_bits;

    assign opcode            = opcode_t'(instr[15:12]);
    assign unused_instr_bits = ^instr[11:8];

    fwd_mux #(.DW(DW), .NFWD(NFWD)) u_fwd_a (
        .fwd_data  (fwd_data),
        .fwd_sel   (fwd_sel_a),
        .reg_data  (reg_data1),
        .data_out  (raw_a),
        .multi_sel (multi_a)
    );

    fwd_mux #(.DW(DW), .NFWD(NFWD)) u_fwd_b (
        .fwd_data  (fwd_data),
        .fwd_sel   (fwd_sel_b),
        .reg_data  (reg_data2),
        .data_out  (raw_b),
        .multi_sel (multi_b)
    );

    assign halted   = (state_q == ST_HALT);
    assign id_ready = !halted && (!ex_valid || ex_ready);
    assign load     = id_valid && id_ready && !flush;

    always_comb begin
        next_a  = raw_a;
        next_b  = raw_b;
        next_op = decode_alu_op(opcode, instr[1:0]);
        case (opcode)
            OP_SUB:                 next_b = ~raw_b;
            OP_SLL, OP_SRA, OP_ROR: next_b = DW'(instr[3:0]);
            OP_LW, OP_SW:           next_b = DW'($signed({instr[3:0], 1'b0}));
            OP_LLB: begin
                next_a = raw_a & ~DW'(16'h00FF);
                next_b = DW'(instr[7:0]);
            end
            OP_LHB: begin
                next_a = raw_a & ~DW'(16'hFF00);
                next_b = DW'({instr[7:0], 8'h00});
            end
            OP_PCS: begin
                next_a = '0;
                next_b = pcs;
            end
            OP_B, OP_BR, OP_HLT: begin
                next_a = '0;
                next_b = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Once halted, only a flush (or reset) lets instructions in again.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (load && opcode == OP_HLT) state_d = ST_HALT;
            ST_HALT: if (flush) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            stall_cnt <= '0;
            fwd_err   <= 1'b0;
        end else begin
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (load) begin
                ex_valid <= 1'b1;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
            if (load) begin
                alu_a  <= next_a;
                alu_b  <= next_b;
                alu_op <= next_op;
            end
            if (load && (multi_a || multi_b)) begin
                fwd_err <= 1'b1;
            end
            if (ex_valid && !ex_ready && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed instructions push expected
// operands; a negedge monitor pops and compares on every transfer out.
module tb_ex_operand_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [15:0] instr;
    logic [15:0] reg_data1;
    logic [15:0] reg_data2;
    logic [15:0] pcs;
    logic [31:0] fwd_data;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [6:0]  alu_op;
    logic        halted;
    logic [7:0]  stall_cnt;
    logic        fwd_err;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [6:0]  op;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    ex_operand_stage #(.DW(16), .NFWD(2), .CW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .instr     (instr),
        .reg_data1 (reg_data1),
        .reg_data2 (reg_data2),
        .pcs       (pcs),
        .fwd_data  (fwd_data),
        .fwd_sel_a (fwd_sel_a),
        .fwd_sel_b (fwd_sel_b),
        .flush     (flush),
        .ex_ready  (ex_ready),
        .ex_valid  (ex_valid),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .halted    (halted),
        .stall_cnt (stall_cnt),
        .fwd_err   (fwd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one instruction, wait (bounded) for acceptance, then release id_valid.
    task automatic applyStimulus(input logic [15:0] i, input logic [15:0] d1, input logic [15:0] d2,
                                 input logic [15:0] pc, input logic [1:0] sa, input logic [1:0] sb,
                                 input logic [31:0] fd, input logic push,
                                 input logic [15:0] ea, input logic [15:0] eb, input logic [6:0] eo);
        int waited;
        exp_t e;
        instr     = i;
        reg_data1 = d1;
        reg_data2 = d2;
        pcs       = pc;
        fwd_sel_a = sa;
        fwd_sel_b = sb;
        fwd_data  = fd;
        id_valid  = 1'b1;
        waited    = 0;
        @(negedge clk);
        while (!id_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!id_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: id_ready stayed 0 for instr %h", i);
        end else if (push) begin
            e.a  = ea;
            e.b  = eb;
            e.op = eo;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 id_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ex_valid && ex_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", {alu_a, alu_b, 25'd0, alu_op}, 64'd0 - 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_a", 64'(alu_a), 64'(e.a));
                    checkOutput("out_b", 64'(alu_b), 64'(e.b));
                    checkOutput("out_op", 64'(alu_op), 64'(e.op));
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; id_valid = 1'b0; instr = '0; reg_data1 = '0; reg_data2 = '0;
        pcs = '0; fwd_data = '0; fwd_sel_a = '0; fwd_sel_b = '0; flush = 1'b0; ex_ready = 1'b1;
        #2;
        checkOutput("rst_ex_valid", 64'(ex_valid), 64'd0);
        checkOutput("rst_halted", 64'(halted), 64'd0);
        checkOutput("rst_fwd_err", 64'(fwd_err), 64'd0);
        checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        checkOutput("rst_alu", {alu_a, alu_b, 25'd0, alu_op}, 64'd0);
        #20 rst = 1'b0;
        idle(1);
        checkOutput("id_ready_idle", 64'(id_ready), 64'd1);

        // instr        d1       d2       pcs      sa     sb     fwd_data        push  a        b        op
        applyStimulus(16'h1000, 16'h0005, 16'h0003, 16'h0, 2'b00, 2'b00, 32'h0, 1'b1, 16'h0005, 16'hFFFC, 7'b0000100);
        applyStimulus(16'hA1AB, 16'h1234, 16'h0000, 16'h0, 2'b00, 2'b00, 32'h0, 1'b1, 16'h0034, 16'hAB00, 7'b0000011);
        applyStimulus(16'h812F, 16'h0100, 16'h0000, 16'h0, 2'b00, 2'b00, 32'h0, 1'b1, 16'h0100, 16'hFFFE, 7'b0000011);
        applyStimulus(16'h3001, 16'hAAAA, 16'h5555, 16'h0, 2'b00, 2'b00, 32'h0, 1'b1, 16'hAAAA, 16'h5555, 7'b0100001);
        applyStimulus(16'h5127, 16'h8000, 16'h1111, 16'h0, 2'b00, 2'b00, 32'h0, 1'b1, 16'h8000, 16'h0007, 7'b1000011);
        applyStimulus(16'h7000, 16'h7F01, 16'h0203, 16'h0, 2'b00, 2'b00, 32'h0, 1'b1, 16'h7F01, 16'h0203, 7'b0010000);
        applyStimulus(16'h2000, 16'h0102, 16'h0304, 16'h0, 2'b00, 2'b00, 32'h0, 1'b1, 16'h0102, 16'h0304, 7'b0001000);
        applyStimulus(16'hB3C5, 16'hBEEF, 16'h0000, 16'h0, 2'b00, 2'b00, 32'h0, 1'b1, 16'hBE00, 16'h00C5, 7'b0000001);
        applyStimulus(16'hE000, 16'h5555, 16'h6666, 16'h0042, 2'b00, 2'b00, 32'h0, 1'b1, 16'h0000, 16'h0042, 7'b0000000);
        applyStimulus(16'h9005, 16'h0200, 16'h0000, 16'h0, 2'b00, 2'b00, 32'h0, 1'b1, 16'h0200, 16'h000A, 7'b0000001);
        applyStimulus(16'h0000, 16'h0001, 16'h0002, 16'h0, 2'b10, 2'b01, 32'h2222_1111, 1'b1, 16'h2222, 16'h1111, 7'b0000000);
        idle(1);
        checkOutput("fwd_err_onehot", 64'(fwd_err), 64'd0);
        applyStimulus(16'h0000, 16'h0001, 16'h0007, 16'h0, 2'b11, 2'b00, 32'h2222_1111, 1'b1, 16'h1111, 16'h0007, 7'b0000000);
        idle(1);
        checkOutput("fwd_err_multi", 64'(fwd_err), 64'd1);
        checkOutput("stall_cnt_flowing", 64'(stall_cnt), 64'd0);

        // Long stall: operands hold, counter saturates, no acceptance.
        ex_ready = 1'b0;
        applyStimulus(16'h0000, 16'h0123, 16'h0456, 16'h0, 2'b00, 2'b00, 32'h0, 1'b1, 16'h0123, 16'h0456, 7'b0000000);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            checkOutput("stall_cnt", 64'(stall_cnt), 64'((k > 255) ? 255 : k));
            checkOutput("stall_hold", {alu_a, alu_b, 25'd0, alu_op}, {16'h0123, 16'h0456, 32'd0});
            checkOutput("stall_id_ready", 64'(id_ready), 64'd0);
            checkOutput("stall_ex_valid", 64'(ex_valid), 64'd1);
        end
        @(posedge clk);
        #1 ex_ready = 1'b1;
        idle(2);
        checkOutput("stall_cnt_sat", 64'(stall_cnt), 64'd255);

        // Halt, blocked issue while halted, then flush back to run.
        applyStimulus(16'hF000, 16'h1234, 16'h5678, 16'h0, 2'b00, 2'b00, 32'h0, 1'b1, 16'h0000, 16'h0000, 7'b0000000);
        @(negedge clk);
        checkOutput("halted_set", 64'(halted), 64'd1);
        checkOutput("halted_id_ready", 64'(id_ready), 64'd0);
        instr = 16'h0000; reg_data1 = 16'h0999; id_valid = 1'b1;
        idle(3);
        checkOutput("halted_no_issue", 64'(ex_valid), 64'd0);
        flush = 1'b1;
        idle(1);
        flush = 1'b0; id_valid = 1'b0;
        checkOutput("flush_halted", 64'(halted), 64'd0);
        checkOutput("flush_ex_valid", 64'(ex_valid), 64'd0);
        checkOutput("flush_id_ready", 64'(id_ready), 64'd1);

        // Flush squashes a stalled instruction.
        ex_ready = 1'b0;
        applyStimulus(16'h0000, 16'h0ABC, 16'h0DEF, 16'h0, 2'b00, 2'b00, 32'h0, 1'b0, 16'h0, 16'h0, 7'b0);
        checkOutput("pre_flush_valid", 64'(ex_valid), 64'd1);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        checkOutput("flush_squash", 64'(ex_valid), 64'd0);
        ex_ready = 1'b1;
        idle(2);

        // Asynchronous reset in the middle of a stall.
        ex_ready = 1'b0;
        applyStimulus(16'h0000, 16'h0777, 16'h0888, 16'h0, 2'b00, 2'b00, 32'h0, 1'b0, 16'h0, 16'h0, 7'b0);
        idle(3);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_ex_valid", 64'(ex_valid), 64'd0);
        checkOutput("arst_alu", {alu_a, alu_b, 25'd0, alu_op}, 64'd0);
        checkOutput("arst_stall_cnt", 64'(stall_cnt), 64'd0);
        checkOutput("arst_fwd_err", 64'(fwd_err), 64'd0);
        checkOutput("arst_halted", 64'(halted), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ex_ready = 1'b1;
        idle(3);
        checkOutput("post_rst_valid", 64'(ex_valid), 64'd0);

        applyStimulus(16'h1000, 16'h0010, 16'h0001, 16'h0, 2'b00, 2'b00, 32'h0, 1'b1, 16'h0010, 16'hFFFE, 7'b0000100);
        idle(3);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Parameter DW, 16, datapath width; legal values 16 or 32.
REQ-002 Parameter NFWD, 2, number of forwarding sources; legal values 1 to 4.
REQ-003 Parameter CW, 8, stall-counter width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 id_valid  in  1  decode stage presents an instruction.
REQ-007 id_ready  out  1  stage can accept an instruction this cycle.
REQ-008 instr  in  16  instruction word; opcode in bits [15:12].
REQ-009 reg_data1, reg_data2  in  DW each  register-file read data for the A and B operands.
REQ-010 pcs  in  DW  PC+2 of the instruction.
REQ-011 fwd_data  in  NFWD*DW  forwarded values; source k occupies slice k.
REQ-012 fwd_sel_a, fwd_sel_b  in  NFWD each  one-hot or zero forward select per operand.
REQ-013 flush  in  1  squash the stage contents.
REQ-014 ex_ready  in  1  execute stage accepts the current output.
REQ-015 ex_valid  out  1  registered outputs are valid.
REQ-016 alu_a, alu_b  out  DW each  registered ALU operands.
REQ-017 alu_op  out  7  registered {out_sel[1:0], sat, red, sub, shiftop[1:0]}.
REQ-018 halted  out  1  an HLT instruction has been accepted.
REQ-019 stall_cnt  out  CW  count of cycles with ex_valid=1 and ex_ready=0.
REQ-020 fwd_err  out  1  sticky flag; a forward select was not one-hot or zero.

Function
REQ-021 Opcode map: 0 ADD, 1 SUB, 2 RED, 3 XOR, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB, 8 LW, 9 SW, A LHB, B LLB, C B, D BR, E PCS, F HLT.
REQ-022 Operand source selection:
  - Raw A is fwd_data slice k when fwd_sel_a[k]=1, otherwise reg_data1.
  - Raw B is selected the same way from fwd_sel_b and reg_data2.
  - If more than one select bit is set, the lowest set index wins.
REQ-023 fwd_err shall set on any accepted instruction with a select vector that is neither one-hot nor zero, and clears only on reset.
REQ-024 Operand formation by opcode:
  - Arithmetic and logic (0,1,2,3,7): A = raw A; B = raw B, bitwise inverted for SUB.
  - Shifts (4,5,6): A = raw A; B = zero-extended instr[3:0].
  - LW/SW: A = raw A; B = sign-extended {instr[3:0],0}.
  - LLB: A = raw A with bits [7:0] cleared; B = zero-extended instr[7:0].
  - LHB: A = raw A with bits [15:8] cleared; B = instr[7:0] placed at bits [15:8], all other bits zero.
  - PCS: A = 0; B = pcs.
  - B, BR, HLT: A = 0; B = 0.
REQ-025 alu_op fields:
  - out_sel = 01 for XOR, 10 for shifts, 00 for everything else.
  - sat = 1 only for PADDSB; red = 1 only for RED; sub = 1 only for SUB.
  - shiftop = instr[1:0].
REQ-026 Handshake: id_ready = !halted && (!ex_valid || ex_ready).
REQ-027 A transfer in occurs when id_valid && id_ready; outputs then load on the next edge, giving one-cycle latency.
REQ-028 When ex_valid=1 and ex_ready=0, alu_a, alu_b and alu_op shall hold stable.
REQ-029 Simultaneous transfer out and transfer in: the new instruction replaces the old one with no bubble.
REQ-030 flush: the next edge sets ex_valid=0, suppresses any same-cycle transfer in, and clears halted.
REQ-031 halted state machine:
  - RUN to HALT when an HLT transfers in without flush.
  - HALT to RUN only on flush or reset.
REQ-032 stall_cnt increments in each cycle with ex_valid && !ex_ready, saturates at 2^CW-1, and never wraps.

Reset
REQ-033 While rst is high, and immediately on its assertion (asynchronous):
  - ex_valid=0, halted=0, fwd_err=0, stall_cnt=0.
  - alu_a=0, alu_b=0, alu_op=0.
REQ-034 Reset asserted mid-stall shall discard the held instruction; no partial output shall appear after release.

Structure
REQ-035 The opcode constants and the alu_op field positions shall live in the shared package cpu_pkg.
REQ-036 The forward-select mux shall be a sub-module fwd_mux (parameters DW, NFWD), instantiated once per operand.

Verification
REQ-037 SUB with reg_data1=0x0005, reg_data2=0x0003, ex_ready=1 -> next cycle alu_a=0x0005, alu_b=0xFFFC, alu_op=0000100.
REQ-038 LHB with instr=0xA1AB, raw A=0x1234 -> alu_a=0x0034, alu_b=0xAB00.
REQ-039 LW with instr[3:0]=0xF -> alu_b=0xFFFE.
REQ-040 ex_ready held 0 for 300 cycles with CW=8 and ex_valid=1:
  - stall_cnt reaches 255 and stays there.
  - Outputs remain unchanged throughout.
  - id_ready=0 throughout.
REQ-041 HLT accepted -> halted=1 and id_ready=0 from the next cycle; flush -> halted=0 and ex_valid=0.
REQ-042 NFWD=2 with fwd_sel_a=11, fwd_data slice0=0x1111 -> alu_a=0x1111 and fwd_err=1; rst pulse mid-operation -> all outputs 0 asynchronously.
